// File: rtl/arm_data_mem_responder.sv
// Data-memory responder: word RAM plus a 32-byte MMIO window (GPIO, timer with compare/IRQ).
// Optional macro DMEM_CYCLE_COUNTER_EN adds a read-only cycle counter at window offset 0x10.
module arm_data_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic          mmio_hit;
  logic [4:0]    off;
  logic [AW-1:0] idx;
  logic          wr_mmio;
  logic          wr_gpio, wr_count, wr_cmp, wr_ctrl;

  logic [31:0] gpio_q, count_q, cmp_q;
  logic        en_q, match_q, autozero_q, irqen_q;

  logic [31:0] count_nxt;
  logic        match_nxt, en_nxt, autozero_nxt, irqen_nxt;
  logic        match_now;
  logic [31:0] cycles_rd;
  logic [31:0] mmio_rd;

  assign mmio_hit = (ALUResult[31:5] == MMIO_BASE[31:5]);
  assign off      = ALUResult[4:0];
  assign idx      = ALUResult[AW+1:2];
  assign wr_mmio  = MemWrite && mmio_hit;
  assign wr_gpio  = wr_mmio && (off == 5'h00);
  assign wr_count = wr_mmio && (off == 5'h04);
  assign wr_cmp   = wr_mmio && (off == 5'h08);
  assign wr_ctrl  = wr_mmio && (off == 5'h0C);

  // RAM is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (MemWrite && !mmio_hit) mem[idx] <= WriteData;
  end

  // A software COUNT write takes priority and suppresses match evaluation on that edge.
  always_comb begin
    match_now    = !wr_count && en_q && (count_q == cmp_q);
    count_nxt    = count_q;
    if (wr_count)       count_nxt = WriteData;
    else if (match_now) count_nxt = autozero_q ? 32'd0 : count_q + 32'd1;
    else if (en_q)      count_nxt = count_q + 32'd1;

    match_nxt    = match_q;
    if (match_now)                    match_nxt = 1'b1;
    else if (wr_ctrl && WriteData[1]) match_nxt = 1'b0;

    en_nxt       = wr_ctrl ? WriteData[0] : en_q;
    autozero_nxt = wr_ctrl ? WriteData[2] : autozero_q;
    irqen_nxt    = wr_ctrl ? WriteData[3] : irqen_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q     <= 32'd0;
      count_q    <= 32'd0;
      cmp_q      <= 32'd0;
      en_q       <= 1'b0;
      match_q    <= 1'b0;
      autozero_q <= 1'b0;
      irqen_q    <= 1'b0;
      timer_irq  <= 1'b0;
    end else begin
      if (wr_gpio) gpio_q <= WriteData;
      if (wr_cmp)  cmp_q  <= WriteData;
      count_q    <= count_nxt;
      match_q    <= match_nxt;
      en_q       <= en_nxt;
      autozero_q <= autozero_nxt;
      irqen_q    <= irqen_nxt;
      timer_irq  <= match_nxt && irqen_nxt;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycles_q;
  always_ff @(posedge clk) begin
    if (reset) cycles_q <= 32'd0;
    else       cycles_q <= cycles_q + 32'd1;
  end
  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = 32'd0;
`endif

  always_comb begin
    mmio_rd = 32'd0;
    unique case (off)
      5'h00:   mmio_rd = gpio_q;
      5'h04:   mmio_rd = count_q;
      5'h08:   mmio_rd = cmp_q;
      5'h0C:   mmio_rd = {28'd0, irqen_q, autozero_q, match_q, en_q};
      5'h10:   mmio_rd = cycles_rd;
      default: mmio_rd = 32'd0;
    endcase
  end

  assign ReadData = mmio_hit ? mmio_rd : mem[idx];
  assign gpio_out = gpio_q;

endmodule
